// File: rtl/credit_vc_rx_buffer.sv
// Receive side of a credit-based NoC link: one FIFO per virtual channel,
// per-VC head presentation with backpressure, and one credit pulse per pop.
module credit_vc_rx_buffer #(
  parameter int A_W           = 8,
  parameter int D_W           = 8,
  parameter int VC_W          = 2,
  parameter int VC_FIFO_DEPTH = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [A_W+D_W:0]                                 i,
  input  logic [VC_W-1:0]                                  i_v,
  output logic [VC_W-1:0]                                  i_credit_gnt,
  output logic [VC_W-1:0][A_W+D_W:0]                       o,
  output logic [VC_W-1:0]                                  o_v,
  input  logic [VC_W-1:0]                                  o_bp,
  output logic [VC_W-1:0][$clog2(VC_FIFO_DEPTH)-1:0]       o_count,
  output logic                                             err
);

  localparam int FW    = A_W + D_W + 1;
  localparam int DEPTH = VC_FIFO_DEPTH - 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(VC_FIFO_DEPTH);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic            multi_hot;
  logic [VC_W-1:0] pop_v;
  logic [VC_W-1:0] ovf_v;

  // More than one valid bit means the sender is broken; nothing is written.
  assign multi_hot = |(i_v & (i_v - VC_W'(1)));

  for (genvar v = 0; v < VC_W; v++) begin : g_vc
    logic [FW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push;

    assign full = (count == FULL_CNT);
    assign pop  = (count != '0) & ~o_bp[v];
    // A full FIFO still accepts when its head leaves on the same edge; the
    // write lands in the slot being vacated since wr_ptr == rd_ptr when full.
    assign push     = i_v[v] & ~multi_hot & (~full | pop);
    assign ovf_v[v] = i_v[v] & ~multi_hot & full & ~pop;
    assign pop_v[v] = pop;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= i;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    assign o[v]       = mem[rd_ptr];
    assign o_v[v]     = (count != '0);
    assign o_count[v] = count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_credit_gnt <= '0;
      err          <= 1'b0;
    end else begin
      i_credit_gnt <= pop_v;
      if (multi_hot || (|ovf_v)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_credit_vc_rx_buffer.sv
// Directed bench for credit_vc_rx_buffer with VC_W=2, VC_FIFO_DEPTH=4 (3 entries/VC).
module tb_credit_vc_rx_buffer;

  localparam int A_W = 8;
  localparam int D_W = 8;
  localparam int FW  = A_W + D_W + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [FW-1:0]        i = '0;
  logic [1:0]           i_v = '0;
  logic [1:0]           i_credit_gnt;
  logic [1:0][FW-1:0]   o;
  logic [1:0]           o_v;
  logic [1:0]           o_bp = '0;
  logic [1:0][1:0]      o_count;
  logic                 err;

  int compared   = 0;
  int mismatched = 0;

  credit_vc_rx_buffer #(
    .A_W(A_W),
    .D_W(D_W),
    .VC_W(2),
    .VC_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i(i),
    .i_v(i_v),
    .i_credit_gnt(i_credit_gnt),
    .o(o),
    .o_v(o_v),
    .o_bp(o_bp),
    .o_count(o_count),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_v  = '0;
    o_bp = '0;
    rst  = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (o_v !== 2'b00) begin mismatched++; $display("FAIL reset_o_v: got %b expected 00", o_v); end
    compared++;
    if (i_credit_gnt !== 2'b00) begin mismatched++; $display("FAIL reset_gnt: got %b expected 00", i_credit_gnt); end
    compared++;
    if (o_count !== 4'h0) begin mismatched++; $display("FAIL reset_count: got %h expected 0", o_count); end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_single();
    o_bp = 2'b00;
    i    = FW'(17'h15);
    i_v  = 2'b01;
    #1;
    compared++;
    if (o_v[0] !== 1'b0) begin mismatched++; $display("FAIL no_bypass: got o_v0=%b expected 0", o_v[0]); end
    step();
    i_v = 2'b00;
    compared++;
    if (o_v[0] !== 1'b1) begin mismatched++; $display("FAIL single_o_v: got %b expected 1", o_v[0]); end
    compared++;
    if (o[0] !== FW'(17'h15)) begin mismatched++; $display("FAIL single_head: got %h expected 15", o[0]); end
    compared++;
    if (o_count[0] !== 2'd1) begin mismatched++; $display("FAIL single_count: got %0d expected 1", o_count[0]); end
    step();
    compared++;
    if (i_credit_gnt !== 2'b01) begin mismatched++; $display("FAIL single_gnt: got %b expected 01", i_credit_gnt); end
    compared++;
    if (o_v !== 2'b00) begin mismatched++; $display("FAIL single_empty: got %b expected 00", o_v); end
    step();
    compared++;
    if (i_credit_gnt !== 2'b00) begin mismatched++; $display("FAIL single_gnt_pulse: got %b expected 00", i_credit_gnt); end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] vals [4];
    vals[0] = FW'(17'hA); vals[1] = FW'(17'hB); vals[2] = FW'(17'hC); vals[3] = FW'(17'hD);
    o_bp = 2'b10;
    for (int k = 0; k < 3; k++) begin
      i   = vals[k];
      i_v = 2'b10;
      step();
      compared++;
      if (i_credit_gnt !== 2'b00) begin mismatched++; $display("FAIL fill_gnt%0d: got %b expected 00", k, i_credit_gnt); end
    end
    compared++;
    if (o_count[1] !== 2'd3) begin mismatched++; $display("FAIL fill_count: got %0d expected 3", o_count[1]); end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL fill_err: got %b expected 0", err); end
    i = vals[3];
    step();
    i_v = 2'b00;
    compared++;
    if (o_count[1] !== 2'd3) begin mismatched++; $display("FAIL ovf_count: got %0d expected 3", o_count[1]); end
    compared++;
    if (err !== 1'b1) begin mismatched++; $display("FAIL ovf_err: got %b expected 1", err); end
    compared++;
    if (o[1] !== FW'(17'hA)) begin mismatched++; $display("FAIL ovf_head: got %h expected a", o[1]); end
  endtask

  task automatic test_drain();
    logic [FW-1:0] exp_q [3];
    exp_q[0] = FW'(17'hA); exp_q[1] = FW'(17'hB); exp_q[2] = FW'(17'hC);
    o_bp = 2'b00;
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (o[1] !== exp_q[k]) begin mismatched++; $display("FAIL drain_head%0d: got %h expected %h", k, o[1], exp_q[k]); end
      step();
      compared++;
      if (i_credit_gnt !== 2'b10) begin mismatched++; $display("FAIL drain_gnt%0d: got %b expected 10", k, i_credit_gnt); end
    end
    compared++;
    if (o_v[1] !== 1'b0 || o_count[1] !== 2'd0) begin
      mismatched++; $display("FAIL drain_empty: got o_v1=%b count=%0d expected 0/0", o_v[1], o_count[1]);
    end
    step();
    compared++;
    if (i_credit_gnt !== 2'b00) begin mismatched++; $display("FAIL drain_gnt_end: got %b expected 00", i_credit_gnt); end
  endtask

  task automatic test_full_push_pop();
    logic [FW-1:0] exp_q [3];
    exp_q[0] = FW'(17'h2); exp_q[1] = FW'(17'h3); exp_q[2] = FW'(17'hE);
    do_reset();
    o_bp = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      i   = FW'(k);
      i_v = 2'b10;
      step();
    end
    i    = FW'(17'hE);
    i_v  = 2'b10;
    o_bp = 2'b00;
    step();
    i_v = 2'b00;
    compared++;
    if (o_count[1] !== 2'd3) begin mismatched++; $display("FAIL pp_count: got %0d expected 3", o_count[1]); end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL pp_err: got %b expected 0", err); end
    compared++;
    if (i_credit_gnt !== 2'b10) begin mismatched++; $display("FAIL pp_gnt: got %b expected 10", i_credit_gnt); end
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (o_v[1] !== 1'b1 || o[1] !== exp_q[k]) begin
        mismatched++; $display("FAIL pp_order%0d: got v=%b %h expected 1 %h", k, o_v[1], o[1], exp_q[k]);
      end
      step();
    end
    compared++;
    if (o_v[1] !== 1'b0) begin mismatched++; $display("FAIL pp_empty: got %b expected 0", o_v[1]); end
    step();
  endtask

  task automatic test_no_hol();
    logic [FW-1:0] got [8];
    int n_got = 0;
    int credits = 0;
    o_bp = 2'b01;
    i    = FW'(17'h55);
    i_v  = 2'b01;
    step();
    i_v = 2'b00;
    for (int c = 0; c < 8; c++) begin
      if (i_credit_gnt[1]) credits++;
      if (o_v[1] && n_got < 8) begin got[n_got] = o[1]; n_got++; end
      if (c < 5) begin i = FW'(17'h20 + c); i_v = 2'b10; end
      else i_v = 2'b00;
      step();
    end
    compared++;
    if (n_got !== 5) begin mismatched++; $display("FAIL hol_n: got %0d expected 5", n_got); end
    for (int k = 0; k < 5 && k < n_got; k++) begin
      compared++;
      if (got[k] !== FW'(17'h20 + k)) begin mismatched++; $display("FAIL hol_flit%0d: got %h expected %h", k, got[k], FW'(17'h20 + k)); end
    end
    compared++;
    if (credits !== 5) begin mismatched++; $display("FAIL hol_credits: got %0d expected 5", credits); end
    compared++;
    if (o_v[0] !== 1'b1 || o[0] !== FW'(17'h55) || o_count[0] !== 2'd1) begin
      mismatched++; $display("FAIL hol_vc0_held: got v=%b %h cnt=%0d expected 1 55 1", o_v[0], o[0], o_count[0]);
    end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL hol_err: got %b expected 0", err); end
  endtask

  task automatic test_multi_hot();
    o_bp = 2'b11;
    i    = FW'(17'h77);
    i_v  = 2'b11;
    step();
    i_v = 2'b00;
    compared++;
    if (o_count !== {2'd0, 2'd1}) begin mismatched++; $display("FAIL mh_count: got %h expected 1", o_count); end
    compared++;
    if (err !== 1'b1) begin mismatched++; $display("FAIL mh_err: got %b expected 1", err); end
    compared++;
    if (o[0] !== FW'(17'h55)) begin mismatched++; $display("FAIL mh_head: got %h expected 55", o[0]); end
  endtask

  task automatic test_async_reset();
    o_bp = 2'b11;
    i = FW'(17'h66); i_v = 2'b01; step();
    i = FW'(17'h67); i_v = 2'b10; step();
    i = FW'(17'h68); i_v = 2'b10; step();
    i_v  = 2'b00;
    o_bp = 2'b10;
    step();
    o_bp = 2'b11;
    compared++;
    if (o_count !== {2'd2, 2'd1} || i_credit_gnt !== 2'b01) begin
      mismatched++; $display("FAIL ar_pre: got cnt=%h gnt=%b expected 9 01", o_count, i_credit_gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (o_v !== 2'b00) begin mismatched++; $display("FAIL ar_o_v: got %b expected 00", o_v); end
    compared++;
    if (o_count !== 4'h0) begin mismatched++; $display("FAIL ar_count: got %h expected 0", o_count); end
    compared++;
    if (i_credit_gnt !== 2'b00) begin mismatched++; $display("FAIL ar_gnt: got %b expected 00", i_credit_gnt); end
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL ar_err: got %b expected 0", err); end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_drain();
    test_full_push_pop();
    test_no_hol();
    test_multi_hot();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
